// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - frame format constants and state encoding shared by transmitter and receiver
package frame_pkg;

   localparam logic [7:0] SYNC_WORD  = 8'h5A;
   localparam int         SYNC_W     = 8;
   localparam int         CTRL_W     = 8;
   localparam int         DATA_W     = 16;
   localparam int         FRAME_BITS = SYNC_W + CTRL_W + 2 * DATA_W;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Widest field; the per-field bit counter must reach this minus one
   localparam int FIELD_MAX = max_int(SYNC_W, max_int(CTRL_W, DATA_W));

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      CTRL,
      DATA_A,
      DATA_B,
      PARITY,
      GAP
   } frame_state_t;

endpackage

// File: rtl/frame_piso.sv
// rtl/frame_piso.sv - parallel-load MSB-first shift register holding one frame
module frame_piso
   import frame_pkg::*;
#(
   parameter int W = FRAME_BITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sreg;

   // Load has priority; a shift moves the next frame bit into the MSB
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= din;
      end else if (shift) begin
         sreg <= {sreg[W-2:0], 1'b0};
      end
   end

   assign msb = sreg[W-1];

endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - serial frame transmitter (sync, ctrl, A, B; parity bit when FRAME_SERIALIZER_PARITY_EN is defined)
module frame_serializer
   import frame_pkg::*;
#(
   parameter int   GAP_CYCLES = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              dout,
   output logic              tx_active,
   output logic              frame_done
);

   // The bit counter also times the inter-frame gap, so size it for both
   localparam int CNT_MAX = max_int(FIELD_MAX, GAP_CYCLES);
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

   frame_state_t  state, state_nxt, after;
   logic [CW-1:0] cnt, cnt_nxt, last_cnt;
   logic          load, shift, emit;
   logic          piso_msb, tx_bit;

   frame_piso #(.W(FRAME_BITS)) u_piso (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .din   ({SYNC_WORD, in_ctrl, in_a, in_b}),
      .msb   (piso_msb)
   );

   assign in_ready = (state == IDLE);

`ifdef FRAME_SERIALIZER_PARITY_EN
   logic parity_q;

   // Even parity over the payload, captured with the frame so later input changes cannot disturb it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else if (load) begin
         parity_q <= ^{in_ctrl, in_a, in_b};
      end
   end

   assign tx_bit = (state == PARITY) ? parity_q : piso_msb;
`else
   assign tx_bit = piso_msb;
`endif

   // State and per-field bit counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Field lengths and successors; every non-idle state runs until its terminal count
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      shift     = 1'b0;
      emit      = 1'b0;
      last_cnt  = '0;
      after     = IDLE;
      case (state)
         SYNC: begin
            emit     = 1'b1;
            shift    = 1'b1;
            last_cnt = CW'(SYNC_W - 1);
            after    = CTRL;
         end
         CTRL: begin
            emit     = 1'b1;
            shift    = 1'b1;
            last_cnt = CW'(CTRL_W - 1);
            after    = DATA_A;
         end
         DATA_A: begin
            emit     = 1'b1;
            shift    = 1'b1;
            last_cnt = CW'(DATA_W - 1);
            after    = DATA_B;
         end
         DATA_B: begin
            emit     = 1'b1;
            shift    = 1'b1;
            last_cnt = CW'(DATA_W - 1);
`ifdef FRAME_SERIALIZER_PARITY_EN
            after    = PARITY;
`else
            if (GAP_CYCLES > 0) after = GAP;
            else                after = IDLE;
`endif
         end
`ifdef FRAME_SERIALIZER_PARITY_EN
         PARITY: begin
            emit     = 1'b1;
            last_cnt = '0;
            if (GAP_CYCLES > 0) after = GAP;
            else                after = IDLE;
         end
`endif
         GAP: begin
            last_cnt = GAP_LAST;
            after    = IDLE;
         end
         default: ;
      endcase

      if (state == IDLE) begin
         if (in_valid) begin
            load      = 1'b1;
            state_nxt = SYNC;
            cnt_nxt   = '0;
         end
      end else if (cnt == last_cnt) begin
         state_nxt = after;
         cnt_nxt   = '0;
      end else begin
         cnt_nxt = cnt + CW'(1);
      end
   end

   // Registered line outputs; frame_done marks the first idle cycle after a frame bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout       <= IDLE_LEVEL;
         tx_active  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dout       <= emit ? tx_bit : IDLE_LEVEL;
         tx_active  <= emit;
         frame_done <= tx_active & ~emit;
      end
   end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Transmit-side counterpart of the serial sequence detector. Accepts one control byte and two 16-bit operands through a valid/ready handshake. Serializes them MSB-first onto a single-bit line as: sync word 0x5A, then control byte, then operand A, then operand B. Sits at the output of the test harness or upstream block and drives the detector's din line directly.

Parameters:
SYNC_WORD, 8'h5A, sync pattern sent first, MSB-first (01011010).
CTRL_W, 8, control field width in bits.
DATA_W, 16, width of each operand field.
GAP_CYCLES, 2, minimum idle bits driven between frames (0 allowed).
IDLE_LEVEL, 1'b0, level driven on dout when no frame is in flight.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  frame request; ctrl/a/b are valid
in_ready  out  1  block can accept a frame this cycle
in_ctrl  in  CTRL_W  control field
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
dout  out  1  serial output, registered
tx_active  out  1  high while any frame bit is on dout
frame_done  out  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset is asynchronous, active-high, on clock clk. Reset values: dout=IDLE_LEVEL, tx_active=0, frame_done=0, state=IDLE, bit counter=0, shift register=0.
- in_ready = (state==IDLE). It is combinational from state only and has no path from in_valid.
- Handshake: a frame is accepted on the rising edge where in_valid && in_ready (edge k). At k, {SYNC_WORD, in_ctrl, in_a, in_b} (48 bits by default) is loaded into the shift register. Later changes to the inputs have no effect on the frame in flight.
- States and transitions:
  - IDLE: accept on handshake, then go to SYNC.
  - SYNC: 8 bits, then CTRL.
  - CTRL: CTRL_W bits, then DATA_A.
  - DATA_A: DATA_W bits, then DATA_B.
  - DATA_B: DATA_W bits, then PARITY if enabled; otherwise GAP if GAP_CYCLES>0, else IDLE.
  - GAP: GAP_CYCLES cycles, then IDLE.
- Bit counter: sized to the widest field. It resets to 0 at each field boundary. Terminal count is field width minus 1.
- Timing:
  - dout = SYNC_WORD[7] after edge k+1.
  - Bit i of the frame (i=0 is the MSB of sync) is on dout after edge k+1+i.
  - With the default widths, the last bit (in_b[0]) is after edge k+48.
- tx_active is 1 for exactly the cycles a frame bit is on dout: 48, or 49 with parity.
- frame_done pulses for one cycle, coincident with the first cycle dout returns to IDLE_LEVEL.
- During GAP, dout=IDLE_LEVEL, in_ready=0, and in_valid is ignored.
- Fastest back-to-back throughput is one frame per (48 + GAP_CYCLES + 1) cycles. The +1 is the IDLE cycle in which the handshake occurs.
- GAP_CYCLES=0: DATA_B goes straight to IDLE, and in_ready is high in the cycle frame_done pulses.
- in_valid held high continuously: each new frame is accepted on the first IDLE cycle.
- in_valid is a no-op outside IDLE; it is neither queued nor lost-counted.
- Reset mid-frame aborts the frame. dout goes to IDLE_LEVEL immediately (asynchronously), there is no frame_done pulse, and in_ready is 1 after reset deasserts.
- The module does not validate in_ctrl; any value is transmitted verbatim.

Optional Feature:
- Macro: FRAME_SERIALIZER_PARITY_EN.
- Defined:
  - PARITY state appends one bit after in_b[0]. The bit is the XOR of all ctrl, A and B bits, giving even parity over the 40 payload bits.
  - Frame length is 49 bits, and tx_active lasts 49 cycles.
- Undefined:
  - No PARITY state and no parity logic; the frame is exactly 48 bits.

Decomposition:
- Package frame_pkg holds:
  - SYNC_WORD, CTRL_W, DATA_W and FRAME_BITS (8+CTRL_W+2*DATA_W).
  - The state enum: IDLE, SYNC, CTRL, DATA_A, DATA_B, PARITY, GAP.
  - The package is shared with the receiver side.
- Sub-module frame_piso is a parallel-load, MSB-first shift register with load and shift enables, width FRAME_BITS. The top level owns the FSM, counters, handshake and parity.

Test Plan:
1. Reset, then in_valid=1, ctrl=8'h01, a=16'h1234, b=16'hABCD -> dout after edges k+1..k+48 = 0101_1010 0000_0001 0001_0010_0011_0100 1010_1011_1100_1101. Then frame_done=1 for one cycle and tx_active=0.
2. in_valid held high for 3 frames, GAP_CYCLES=2 -> handshakes exactly 51 cycles apart, and dout=IDLE_LEVEL for 3 cycles between frames.
3. Change in_a to 16'hFFFF at k+10 during a frame with a=16'h0000 -> transmitted A bits all 0, and in_ready stays 0 until IDLE.
4. Assert reset at k+20 -> dout=0 and tx_active=0 in the same cycle, no frame_done, and in_ready=1 on the first edge after release.
5. Feed the output to the sequence detector with ctrl=8'h01 -> detector raises detected and captures matching a/b. Compare the detector's register contents against the expected fields as the protocol-level check.
6. With FRAME_SERIALIZER_PARITY_EN, ctrl=8'h01, a=16'h0001, b=16'h0000 -> 49th bit = 0 (two 1s). With b=16'h0001 instead, the bit = 1.
